// File: rtl/subtree_pkg.sv
// Shared types and constants for the subtree status collector.
package subtree_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    NEXT,
    REPORT
  } state_e;

  localparam int unsigned NUM_CHILD_DEF = 5;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned TIMEOUT_DEF   = 255;
  // Wide enough for any TIMEOUT in 1..65535
  localparam int unsigned TMR_W         = 16;

  // Accumulator width: room for NUM_CHILD full-scale words without wrap
  function automatic int unsigned sum_w(input int unsigned nc, input int unsigned dw);
    return dw + $clog2(nc + 1);
  endfunction

endpackage

// File: rtl/subtree_status_collector_if.sv
// Child poll bus plus aggregated report handshake.
interface subtree_status_collector_if #(
  parameter int unsigned NUM_CHILD = subtree_pkg::NUM_CHILD_DEF,
  parameter int unsigned DATA_W    = subtree_pkg::DATA_W_DEF
);
  import subtree_pkg::*;

  localparam int unsigned SUM_W = sum_w(NUM_CHILD, DATA_W);

  logic [NUM_CHILD-1:0]        child_req;
  logic [NUM_CHILD-1:0]        child_ack;
  logic [NUM_CHILD*DATA_W-1:0] child_data;
  logic [NUM_CHILD-1:0]        child_err;
  logic                        out_valid;
  logic                        out_ready;
  logic [SUM_W-1:0]            out_sum;
  logic [NUM_CHILD-1:0]        out_err_mask;
  logic [NUM_CHILD-1:0]        out_to_mask;

  modport master (
    output child_req, out_valid, out_sum, out_err_mask, out_to_mask,
    input  child_ack, child_data, child_err, out_ready
  );

  modport slave (
    input  child_req, out_valid, out_sum, out_err_mask, out_to_mask,
    output child_ack, child_data, child_err, out_ready
  );

endinterface

// File: rtl/subtree_timeout_ctr.sv
// Loadable down-counter; expired_o is high while the count is zero.
module subtree_timeout_ctr
  import subtree_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats decrement; saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (load_i)                cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/subtree_status_collector.sv
// Polls each child in index order, accumulates clean results, flags
// error/timeout children and presents one report per sweep.
module subtree_status_collector
  import subtree_pkg::*;
#(
  parameter int unsigned NUM_CHILD = NUM_CHILD_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  subtree_status_collector_if.master bus
);

  localparam int unsigned SUM_W = sum_w(NUM_CHILD, DATA_W);
  localparam int unsigned IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);
  // Timer counts down from TIMEOUT-1, so expiry lands on the same WAIT
  // cycle as an up-counter reaching TIMEOUT-1.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [NUM_CHILD-1:0] err_q, err_d;
  logic [NUM_CHILD-1:0] to_q, to_d;
  logic [NUM_CHILD-1:0] req_q, req_d;
  logic                 tmr_clr, tmr_load, tmr_dec, tmr_exp;
  logic                 sel_ack, sel_err;
  logic [DATA_W-1:0]    sel_data;

  subtree_timeout_ctr #(.W(TMR_W)) u_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (TMR_LOAD),
    .expired_o  (tmr_exp)
  );

  // Select the ack/err/data of the child currently being polled
  always_comb begin
    sel_ack  = 1'b0;
    sel_err  = 1'b0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_CHILD; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ack  = bus.child_ack[i];
        sel_err  = bus.child_err[i];
        sel_data = bus.child_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state, accumulator, mask and request logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    err_d    = err_q;
    to_d     = to_q;
    req_d    = req_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (start) begin
          sum_d   = '0;
          err_d   = '0;
          to_d    = '0;
          idx_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        req_d        = '0;
        req_d[idx_q] = 1'b1;
        tmr_load     = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        // Ack is checked before expiry so a same-cycle ack wins
        if (sel_ack) begin
          if (sel_err) err_d[idx_q] = 1'b1;
          else         sum_d = sum_q + SUM_W'(sel_data);
          req_d   = '0;
          state_d = NEXT;
        end else if (tmr_exp) begin
          to_d[idx_q] = 1'b1;
          req_d       = '0;
          state_d     = NEXT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = REPORT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = REQ;
        end
      end
      REPORT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      err_q   <= '0;
      to_q    <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      to_q    <= to_d;
      req_q   <= req_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign bus.out_valid    = (state_q == REPORT);
  assign bus.child_req    = req_q;
  assign bus.out_sum      = sum_q;
  assign bus.out_err_mask = err_q;
  assign bus.out_to_mask  = to_q;

endmodule

// File: tb/tb_subtree_status_collector.sv
// Directed bench with a per-child responder model and a reference model
// deriving each sweep's report and per-child request lengths.
module tb_subtree_status_collector;

  localparam int NC = 5;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int SW = 19;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;

  int compared   = 0;
  int mismatched = 0;
  int accepted   = 0;

  // Child behaviour: lat<0 never acks, else acks lat cycles after req appears
  int            lat[NC];
  logic          err_cfg[NC];
  logic [DW-1:0] dat[NC];
  int            stray_child = -1;

  logic [SW-1:0] exp_sum;
  logic [NC-1:0] exp_err, exp_to;
  int            exp_len[NC];

  logic [SW-1:0] cap_sum;
  logic [NC-1:0] cap_err, cap_to;
  int            last_len[NC];

  subtree_status_collector_if #(.NUM_CHILD(NC), .DATA_W(DW)) bus ();

  subtree_status_collector #(
    .NUM_CHILD (NC),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: which children answer in time, what the report must hold,
  // and how long each request must stay up.
  function automatic void model();
    exp_sum = '0;
    exp_err = '0;
    exp_to  = '0;
    for (int i = 0; i < NC; i++) begin
      if (lat[i] >= 0 && lat[i] < TO) begin
        exp_len[i] = lat[i] + 1;
        if (err_cfg[i]) exp_err[i] = 1'b1;
        else            exp_sum = exp_sum + SW'(dat[i]);
      end else begin
        exp_to[i]  = 1'b1;
        exp_len[i] = TO;
      end
    end
  endfunction

  // Child responders
  initial begin : responder
    int cnt[NC];
    foreach (cnt[i]) cnt[i] = 0;
    bus.child_ack  = '0;
    bus.child_err  = '0;
    bus.child_data = {NC{16'hDEAD}};
    forever begin
      @(posedge clk);
      #1;
      bus.child_ack = '0;
      bus.child_err = '0;
      for (int i = 0; i < NC; i++) begin
        bus.child_data[i*DW +: DW] = 16'hDEAD;
        if (bus.child_req[i]) cnt[i]++;
        else                  cnt[i] = 0;
        if (bus.child_req[i] && lat[i] >= 0 && cnt[i] == lat[i] + 1) begin
          bus.child_ack[i]           = 1'b1;
          bus.child_err[i]           = err_cfg[i];
          bus.child_data[i*DW +: DW] = dat[i];
        end
      end
      if (stray_child >= 0 && bus.child_req[0] && cnt[0] == 1) begin
        bus.child_ack[stray_child]           = 1'b1;
        bus.child_data[stray_child*DW +: DW] = 16'h7777;
      end
    end
  end

  // Per-cycle compare against the reference model
  initial begin : monitor
    int            len[NC];
    logic [NC-1:0] prev;
    prev = '0;
    foreach (len[i]) len[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
        foreach (len[i]) len[i] = 0;
      end else begin
        check("req_onehot0", 64'($onehot0(bus.child_req)), 64'd1);
        if (bus.out_valid) begin
          check("rpt_sum", 64'(bus.out_sum), 64'(exp_sum));
          check("rpt_err_mask", 64'(bus.out_err_mask), 64'(exp_err));
          check("rpt_to_mask", 64'(bus.out_to_mask), 64'(exp_to));
          if (bus.out_ready) begin
            accepted++;
            cap_sum = bus.out_sum;
            cap_err = bus.out_err_mask;
            cap_to  = bus.out_to_mask;
          end
        end
        for (int i = 0; i < NC; i++) begin
          if (bus.child_req[i]) begin
            len[i]++;
          end else if (prev[i]) begin
            last_len[i] = len[i];
            check($sformatf("req_len[%0d]", i), 64'(len[i]), 64'(exp_len[i]));
            len[i] = 0;
          end
        end
        prev = bus.child_req;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_report();
    int n = 0;
    while (!bus.out_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("report_arrives", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic sweep(input logic rdy);
    model();
    bus.out_ready = rdy;
    do_start();
    check("busy_after_start", 64'(busy), 64'd1);
    wait_report();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int a0;
    lat     = '{1, 1, 1, 1, 1};
    err_cfg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dat     = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(bus.child_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.out_sum), 64'd0);
    check("rst_masks", 64'({bus.out_err_mask, bus.out_to_mask}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic clean sweep
    lat = '{1, 1, 1, 1, 1};
    dat = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    a0  = accepted;
    sweep(1'b1);
    @(posedge clk); #1;
    check("t1_valid_one_cycle", 64'(bus.out_valid), 64'd0);
    check("t1_busy_low", 64'(busy), 64'd0);
    check("t1_accepted", 64'(accepted - a0), 64'd1);
    check("t1_sum", 64'(cap_sum), 64'd150);
    check("t1_masks", 64'({cap_err, cap_to}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_sum_held", 64'(bus.out_sum), 64'd150);

    // Error and timeout
    lat     = '{1, 1, 1, 1, -1};
    err_cfg = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    dat     = '{16'd1, 16'd1, 16'hFFFF, 16'd1, 16'd1};
    sweep(1'b1);
    @(posedge clk); #1;
    check("t2_sum", 64'(cap_sum), 64'd3);
    check("t2_err_mask", 64'(cap_err), 64'b00100);
    check("t2_to_mask", 64'(cap_to), 64'b10000);
    check("t2_req4_len", 64'(last_len[4]), 64'd8);
    err_cfg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Back-pressure with an ignored start
    lat = '{0, 2, 1, 3, 0};
    dat = '{16'h0100, 16'h0020, 16'h0003, 16'h1000, 16'h0004};
    a0  = accepted;
    sweep(1'b0);
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      check("t3_valid_held", 64'(bus.out_valid), 64'd1);
      check("t3_busy_held", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("t3_no_accept_early", 64'(accepted - a0), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_valid_dropped", 64'(bus.out_valid), 64'd0);
    check("t3_accepted", 64'(accepted - a0), 64'd1);
    check("t3_sum", 64'(cap_sum), 64'h1127);
    repeat (10) @(posedge clk);
    #1;
    check("t3_start_ignored", 64'(busy), 64'd0);
    check("t3_single_report", 64'(accepted - a0), 64'd1);

    // Ack on the timeout cycle, stray ack from child 3
    lat         = '{1, 7, 1, 1, 1};
    dat         = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    stray_child = 3;
    sweep(1'b1);
    @(posedge clk); #1;
    stray_child = -1;
    check("t4_sum", 64'(cap_sum), 64'd35);
    check("t4_to_mask", 64'(cap_to), 64'd0);
    check("t4_err_mask", 64'(cap_err), 64'd0);
    check("t4_req1_len", 64'(last_len[1]), 64'd8);

    // Reset while waiting on child 2
    lat = '{1, 1, -1, 1, 1};
    dat = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
    a0  = accepted;
    model();
    bus.out_ready = 1'b1;
    do_start();
    begin
      int n = 0;
      while (!bus.child_req[2] && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("t5_reached_child2", 64'(bus.child_req), 64'b00100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_req_async", 64'(bus.child_req), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_valid", 64'(bus.out_valid), 64'd0);
    check("t5_sum_clr", 64'(bus.out_sum), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t5_no_partial", 64'(accepted - a0), 64'd0);
    lat = '{1, 1, 1, 1, 1};
    dat = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
    sweep(1'b1);
    @(posedge clk); #1;
    check("t5_sum", 64'(cap_sum), 64'd1500);
    check("t5_masks", 64'({cap_err, cap_to}), 64'd0);
    check("t5_accepted", 64'(accepted - a0), 64'd1);

    // Full-scale sum
    lat = '{0, 0, 0, 0, 0};
    dat = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    sweep(1'b1);
    @(posedge clk); #1;
    check("t6_sum", 64'(cap_sum), 64'h4FFFB);
    check("t6_masks", 64'({cap_err, cap_to}), 64'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/subtree_status_collector.md
Name: subtree_status_collector

Overview:
- Downstream consumer for one generated subtree level, for example the five leaf instances under a rootModule node.
- Polls each child instance in index order using a req/ack handshake and accumulates the children's result words.
- Flags children that report an error or fail to answer within a timeout.
- Emits one aggregated report per sweep on a valid/ready output, which feeds the next level up of the hierarchy test harness.

Parameters:
- NUM_CHILD, 5, number of child instances polled per sweep (1..16).
- DATA_W, 16, width of each child result word.
- TIMEOUT, 255, cycles to wait for ack before declaring a child timed out (1..65535).
- SUM_W, DATA_W+$clog2(NUM_CHILD+1), width of the accumulated sum (derived; do not override).

Ports:
- clk, input, 1, single clock; all logic rises on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins a sweep; ignored while busy=1.
- child_req, output, NUM_CHILD, one-hot request to the child currently being polled.
- child_ack, input, NUM_CHILD, per-child acknowledge; a child's data and err are valid in the cycle its ack=1.
- child_data, input, NUM_CHILD*DATA_W, packed result words; child i occupies bits [i*DATA_W +: DATA_W].
- child_err, input, NUM_CHILD, per-child error flag, qualified by ack.
- busy, output, 1, high from the cycle after an accepted start until the report handshake completes.
- out_valid, output, 1, aggregated report valid.
- out_ready, input, 1, downstream accepts the report.
- out_sum, output, SUM_W, sum of data from all children that acked without error.
- out_err_mask, output, NUM_CHILD, bit i set if child i acked with err=1.
- out_to_mask, output, NUM_CHILD, bit i set if child i timed out.

Behaviour:
- Reset (async assert, synchronous-safe deassert): state=IDLE; child_req=0, busy=0, out_valid=0, out_sum=0, both masks=0, index=0, timer=0.
- State IDLE:
  - On start=1: clear the accumulator and masks, set idx=0, go to REQ.
  - start=1 in any other state has no effect.
- State REQ (1 cycle): drive child_req=1<<idx, clear the timer, go to WAIT.
- State WAIT: child_req stays asserted.
  - If child_ack[idx]=1 and child_err[idx]=0: add zero-extended data to the accumulator.
  - If child_ack[idx]=1 and child_err[idx]=1: set err_mask[idx] and do not add the data.
  - In either ack case, drop req in the next cycle and go to NEXT.
  - If no ack arrives and timer==TIMEOUT-1: set to_mask[idx], drop req, go to NEXT.
  - Otherwise increment the timer.
  - An ack arriving in the same cycle as the timeout wins; the timeout is not flagged.
- Ack sampling:
  - Acks on non-selected children are ignored.
  - An ack arriving after the poller has moved on is ignored.
- State NEXT (1 cycle):
  - If idx==NUM_CHILD-1, go to REPORT.
  - Otherwise idx++ and go to REQ.
  - Minimum per-child cost is 3 cycles (REQ, WAIT with immediate ack, NEXT).
- State REPORT:
  - out_valid=1 and the outputs are held stable until out_ready=1.
  - On the handshake, out_valid drops next cycle, busy drops, state returns to IDLE.
  - out_sum and the masks keep their last reported values until the next start.
- Accumulator arithmetic: SUM_W wide, so it cannot overflow with NUM_CHILD full-scale words; no saturation logic.
- child_req is one-hot or zero at all times and is never asserted outside REQ/WAIT.
- Reset mid-sweep: all state clears immediately; child_req drops asynchronously; no partial report is produced.

Decomposition:
- Shared package subtree_pkg holds:
  - the state enum typedef (IDLE, REQ, WAIT, NEXT, REPORT);
  - the localparam defaults for NUM_CHILD and DATA_W;
  - a function computing SUM_W.
- One natural sub-module: subtree_timeout_ctr, a loadable down-counter with a clear input and an expiry flag.
- Index mux, accumulator and FSM stay in the top module.

Test Plan:
- Basic sweep, all clean:
  - Stimulus: all children ack 1 cycle after req with err=0; data = 10, 20, 30, 40, 50; out_ready held at 1.
  - Required: out_sum=150, err_mask=0, to_mask=0; out_valid asserted exactly 1 cycle; busy low afterwards.
- Error and timeout:
  - Stimulus: TIMEOUT=8; child 2 acks with err=1 and data=0xFFFF; child 4 never acks; others return data=1.
  - Required: out_sum=3, err_mask=5'b00100, to_mask=5'b10000; req to child 4 lasts exactly 8 cycles.
- Back-pressure:
  - Stimulus: out_ready held at 0 for 20 cycles after out_valid rises; start pulsed during that time.
  - Required: out_valid and the outputs stay stable, the start is ignored, and exactly one report is accepted when ready rises.
- Ack/timeout collision and stray acks:
  - Stimulus: child 1 acks in the timeout cycle; child 3 pulses ack while child 0 is being polled.
  - Required: no to_mask bit for child 1 and its data is added; the stray child 3 ack changes nothing.
- Reset mid-sweep:
  - Stimulus: assert rst_n=0 while in WAIT on child 2.
  - Required: child_req=0 in the same cycle, busy=0, out_valid=0; a fresh start then produces a correct full report.
- Full-scale sum:
  - Stimulus: all five children return 0xFFFF.
  - Required: out_sum=0x4FFFB with SUM_W=19 and no wrap.
